// File: rtl/rip_nr1w_bram_pkg.sv
// Shared constants and types for the N-read 1-write byte-enable block RAM.
// Provides the byte width used to split words into strobed lanes and the
// state encoding of the post-reset clear sequencer.
package rip_nr1w_bram_pkg;

    localparam int B_WIDTH = 8;

    typedef enum logic {
        BRAM_CLEAR,
        BRAM_READY
    } bram_state_e;

endpackage

// File: rtl/rip_nr1w_bram_if.sv
// Bus bundle for rip_nr1w_bram: one byte-strobed write port plus N_READ
// independent read ports, and a busy flag raised while the clear sweep runs.
// master: drives w_*, r_enable, r_addr; slave: drives busy, r_dout, r_valid.
interface rip_nr1w_bram_if
    import rip_nr1w_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int N_READ     = 2
) ();

    localparam int NB = DATA_WIDTH / B_WIDTH;

    logic                                   busy;
    logic                                   w_enable;
    logic [ADDR_WIDTH-1:0]                  w_addr;
    logic [NB-1:0]                          w_we;
    logic [DATA_WIDTH-1:0]                  w_din;
    logic [N_READ-1:0]                      r_enable;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]      r_addr;
    logic [N_READ-1:0][DATA_WIDTH-1:0]      r_dout;
    logic [N_READ-1:0]                      r_valid;

    modport master (
        input  busy, r_dout, r_valid,
        output w_enable, w_addr, w_we, w_din, r_enable, r_addr
    );

    modport slave (
        output busy, r_dout, r_valid,
        input  w_enable, w_addr, w_we, w_din, r_enable, r_addr
    );

endinterface

// File: rtl/rip_nr1w_bram_bank.sv
// One 1R1W byte-enable block RAM bank with a registered read output.
// Ports: w_en/w_addr/w_be/w_din write port; r_en/r_addr read port;
// r_dout holds the last read word (cleared by rst). WRITE_FIRST selects
// whether a same-address read sees the bytes being written this cycle.
module rip_1r1w_bram_bank
    import rip_nr1w_bram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WRITE_FIRST = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               w_en,
    input  logic [ADDR_WIDTH-1:0]              w_addr,
    input  logic [DATA_WIDTH/B_WIDTH-1:0]      w_be,
    input  logic [DATA_WIDTH-1:0]              w_din,
    input  logic                               r_en,
    input  logic [ADDR_WIDTH-1:0]              r_addr,
    output logic [DATA_WIDTH-1:0]              r_dout
);

    localparam int NB = DATA_WIDTH / B_WIDTH;

    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // Write-first bypass: merge the strobed bytes over the old word.
    always_comb begin
        dout_d = mem[r_addr];
        if (WRITE_FIRST != 0 && w_en && w_addr == r_addr) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    dout_d[b*B_WIDTH +: B_WIDTH] = w_din[b*B_WIDTH +: B_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    mem[w_addr][b*B_WIDTH +: B_WIDTH] <= w_din[b*B_WIDTH +: B_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (r_en) begin
            dout_q <= dout_d;
        end
    end

    assign r_dout = dout_q;

endmodule

// File: rtl/rip_nr1w_bram.sv
// N-read 1-write byte-enable BRAM: one replicated bank per read port, shared
// write port, optional second output register and a post-reset clear sweep.
// Ports: clk, rst (sync, active high), bus (slave side of rip_nr1w_bram_if).
module rip_nr1w_bram
    import rip_nr1w_bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int N_READ         = 2,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst,
    rip_nr1w_bram_if.slave bus
);

    localparam int NB = DATA_WIDTH / B_WIDTH;

    if (DATA_WIDTH % B_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of B_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (N_READ < 1 || N_READ > 8) begin : g_bad_nread
        $error("N_READ must be in 1..8");
    end

    bram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_din;

    logic [N_READ-1:0]                 rd_en;
    logic [N_READ-1:0]                 v1_d, v1_q;
    logic [N_READ-1:0][DATA_WIDTH-1:0] bank_dout;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            BRAM_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = BRAM_READY;
                end
            end
            BRAM_READY: begin
                clr_addr_d = '0;
            end
            default: begin
                state_d = BRAM_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? BRAM_CLEAR : BRAM_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The sweep owns the write port while clearing; user traffic is dropped.
    always_comb begin
        if (state_q == BRAM_CLEAR) begin
            wr_en   = !rst;
            wr_addr = clr_addr_q;
            wr_be   = '1;
            wr_din  = '0;
        end else begin
            wr_en   = bus.w_enable && !rst;
            wr_addr = bus.w_addr;
            wr_be   = bus.w_we;
            wr_din  = bus.w_din;
        end
        rd_en = (state_q == BRAM_READY && !rst) ? bus.r_enable : '0;
        v1_d  = rd_en;
    end

    for (genvar p = 0; p < N_READ; p++) begin : g_bank
        rip_1r1w_bram_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .WRITE_FIRST (WRITE_FIRST)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .w_en   (wr_en),
            .w_addr (wr_addr),
            .w_be   (wr_be),
            .w_din  (wr_din),
            .r_en   (rd_en[p]),
            .r_addr (bus.r_addr[p]),
            .r_dout (bank_dout[p])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= '0;
        end else begin
            v1_q <= v1_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [N_READ-1:0]                 v2_q;
        logic [N_READ-1:0][DATA_WIDTH-1:0] dout2_d, dout2_q;

        // Only advance a port's output stage when a read landed in the bank.
        always_comb begin
            dout2_d = dout2_q;
            for (int p = 0; p < N_READ; p++) begin
                if (v1_q[p]) begin
                    dout2_d[p] = bank_dout[p];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q    <= '0;
                dout2_q <= '0;
            end else begin
                v2_q    <= v1_q;
                dout2_q <= dout2_d;
            end
        end

        assign bus.r_dout  = dout2_q;
        assign bus.r_valid = v2_q;
    end else begin : g_lat1
        assign bus.r_dout  = bank_dout;
        assign bus.r_valid = v1_q;
    end

    assign bus.busy = (state_q == BRAM_CLEAR);

endmodule
